// File: rtl/rv4028_bus_responder.sv
// RV4028 bus target: claims a configurable address window, inserts wait states
// on wait_n, and serves 16-bit reads and byte-masked writes from word memory.
module rv4028_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_BITS   = 8,
    parameter bit          IO_SPACE    = 1'b0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [1:0]  msk_n,
    input  logic        iorq_n,
    input  logic        req_n,
    input  logic [15:0] data_in,
    output logic        wait_n,
    output logic [15:0] data_out,
    output logic        data_oe
);

    localparam int unsigned IW    = ADDR_BITS - 1;
    localparam int unsigned WORDS = 1 << IW;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [IW-1:0]  idx_q;
    logic [1:0]     msk_q;
    logic           wr_q;
    logic [15:0]    mem [WORDS];

    logic           sel;
    logic [IW-1:0]  idx_cur;
    logic           unused_addr_bit;

    function automatic logic [15:0] merge(input logic [15:0] old_w,
                                          input logic [15:0] new_w,
                                          input logic [1:0]  m_n);
        logic [15:0] r;
        r = old_w;
        if (!m_n[0]) r[7:0]  = new_w[7:0];
        if (!m_n[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // Simultaneous rd_n/wr_n low is rejected by the XOR term.
    always_comb begin
        sel = !req_n && (rd_n ^ wr_n) && (iorq_n == !IO_SPACE)
              && (addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
        idx_cur = addr[ADDR_BITS-1:1];
        unused_addr_bit = addr[0];
    end

    // Memory is deliberately left out of the reset branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_n   <= 1'b1;
            data_oe  <= 1'b0;
            data_out <= '0;
            cnt      <= '0;
            idx_q    <= '0;
            msk_q    <= '1;
            wr_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel) begin
                        idx_q <= idx_cur;
                        msk_q <= msk_n;
                        wr_q  <= !wr_n;
                        if (WS != 4'd0) begin
                            state  <= ST_WAIT;
                            cnt    <= WS;
                            wait_n <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            if (!wr_n) begin
                                mem[idx_cur] <= merge(mem[idx_cur], data_in, msk_n);
                            end else begin
                                data_oe  <= 1'b1;
                                data_out <= mem[idx_cur];
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (req_n) begin
                        state  <= ST_IDLE;
                        wait_n <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        state  <= ST_DONE;
                        wait_n <= 1'b1;
                        if (wr_q) begin
                            mem[idx_q] <= merge(mem[idx_q], data_in, msk_q);
                        end else begin
                            data_oe  <= 1'b1;
                            data_out <= mem[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (req_n) begin
                        state    <= ST_IDLE;
                        data_oe  <= 1'b0;
                        data_out <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_n   <= 1'b1;
                    data_oe  <= 1'b0;
                    data_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv4028_bus_responder.sv
// Directed bench: three responders (2, 3 and 0 wait states) share the bus signals
// and each has its own req_n; expected values are hand-computed constants.
module tb_rv4028_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd_n, wr_n, iorq_n;
    logic [1:0]  msk_n;
    logic [15:0] data_in;
    logic [2:0]  req_n;
    logic [2:0]  wait_n_v;
    logic [2:0]  oe_v;
    logic [15:0] dout_v [3];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rv4028_bus_responder #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(8), .IO_SPACE(1'b0), .WAIT_STATES(2))
    u_w2 (.clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
          .iorq_n(iorq_n), .req_n(req_n[0]), .data_in(data_in), .wait_n(wait_n_v[0]),
          .data_out(dout_v[0]), .data_oe(oe_v[0]));

    rv4028_bus_responder #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(8), .IO_SPACE(1'b0), .WAIT_STATES(3))
    u_w3 (.clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
          .iorq_n(iorq_n), .req_n(req_n[1]), .data_in(data_in), .wait_n(wait_n_v[1]),
          .data_out(dout_v[1]), .data_oe(oe_v[1]));

    rv4028_bus_responder #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(8), .IO_SPACE(1'b0), .WAIT_STATES(0))
    u_w0 (.clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .msk_n(msk_n),
          .iorq_n(iorq_n), .req_n(req_n[2]), .data_in(data_in), .wait_n(wait_n_v[2]),
          .data_out(dout_v[2]), .data_oe(oe_v[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        check_eq({tag, "_wait_n"}, 32'(wait_n_v[k]), 32'd1);
        check_eq({tag, "_data_oe"}, 32'(oe_v[k]), 32'd0);
        check_eq({tag, "_data_out"}, 32'(dout_v[k]), 32'h0);
    endtask

    // Called at a negedge; returns at a negedge one idle cycle after release.
    task automatic access(input int k, input int w, input logic [31:0] a, input bit is_wr,
                          input logic [1:0] m, input logic [15:0] d, input logic [15:0] exp);
        addr = a; rd_n = is_wr; wr_n = !is_wr; msk_n = m; data_in = d; iorq_n = 1'b1;
        req_n[k] = 1'b0;
        for (int c = 1; c <= w + 2; c++) begin
            @(negedge clk);
            if (c <= w) begin
                check_eq("wait_low", 32'(wait_n_v[k]), 32'd0);
                check_eq("oe_in_wait", 32'(oe_v[k]), 32'd0);
                check_eq("dout_in_wait", 32'(dout_v[k]), 32'h0);
            end else begin
                check_eq("wait_high_done", 32'(wait_n_v[k]), 32'd1);
                check_eq("oe_done", 32'(oe_v[k]), is_wr ? 32'd0 : 32'd1);
                check_eq(is_wr ? "dout_wr_done" : "read_data", 32'(dout_v[k]),
                         is_wr ? 32'h0 : 32'(exp));
            end
            if (c == 1) begin
                addr  = a ^ 32'h2;
                msk_n = ~m;
            end
        end
        req_n[k] = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check_idle(k, "after_release");
    endtask

    task automatic miss(input int k, input logic [31:0] a, input logic rd, input logic wr,
                        input logic io, input logic [15:0] d);
        addr = a; rd_n = rd; wr_n = wr; iorq_n = io; msk_n = 2'b00; data_in = d;
        req_n[k] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle(k, "miss");
        end
        req_n[k] = 1'b1; rd_n = 1'b1; wr_n = 1'b1; iorq_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; rd_n = 1'b1; wr_n = 1'b1; iorq_n = 1'b1;
        msk_n = 2'b11; data_in = '0; req_n = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) check_idle(k, "reset_idle");
        end

        // W=2: full write then read back
        access(0, 2, 32'h0000_1010, 1'b1, 2'b00, 16'hBEEF, 16'h0);
        access(0, 2, 32'h0000_1010, 1'b0, 2'b00, 16'h0, 16'hBEEF);

        // Byte lanes
        access(0, 2, 32'h0000_1004, 1'b1, 2'b00, 16'h1234, 16'h0);
        access(0, 2, 32'h0000_1004, 1'b1, 2'b01, 16'hAB00, 16'h0);
        access(0, 2, 32'h0000_1004, 1'b0, 2'b00, 16'h0, 16'hAB34);
        access(0, 2, 32'h0000_1004, 1'b1, 2'b10, 16'h00CD, 16'h0);
        access(0, 2, 32'h0000_1004, 1'b0, 2'b00, 16'h0, 16'hABCD);
        access(0, 2, 32'h0000_1004, 1'b1, 2'b11, 16'hFFFF, 16'h0);
        access(0, 2, 32'h0000_1004, 1'b0, 2'b00, 16'h0, 16'hABCD);

        // Decode misses
        miss(0, 32'h2000_0000, 1'b0, 1'b1, 1'b1, 16'h0);
        miss(0, 32'h0000_1010, 1'b0, 1'b1, 1'b0, 16'h0);
        miss(0, 32'h0000_1010, 1'b1, 1'b0, 1'b0, 16'h5555);
        miss(0, 32'h0000_1010, 1'b0, 1'b0, 1'b1, 16'h5555);
        miss(0, 32'h2000_1010, 1'b1, 1'b0, 1'b1, 16'h5555);
        access(0, 2, 32'h0000_1010, 1'b0, 2'b00, 16'h0, 16'hBEEF);

        // W=3: abort by req_n after one wait cycle
        access(1, 3, 32'h0000_1020, 1'b1, 2'b00, 16'h1111, 16'h0);
        addr = 32'h0000_1020; rd_n = 1'b1; wr_n = 1'b0; msk_n = 2'b00; data_in = 16'h2222;
        req_n[1] = 1'b0;
        @(negedge clk);
        check_eq("abort_wait_low", 32'(wait_n_v[1]), 32'd0);
        req_n[1] = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check_idle(1, "abort_idle");
        access(1, 3, 32'h0000_1020, 1'b0, 2'b00, 16'h0, 16'h1111);

        // W=3: reset mid-WAIT
        addr = 32'h0000_1020; rd_n = 1'b1; wr_n = 1'b0; msk_n = 2'b00; data_in = 16'h3333;
        req_n[1] = 1'b0;
        @(negedge clk);
        check_eq("rst_wait_low", 32'(wait_n_v[1]), 32'd0);
        rst_n = 1'b0; req_n[1] = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        check_idle(1, "rst_mid_idle");
        rst_n = 1'b1;
        @(negedge clk);
        access(1, 3, 32'h0000_1020, 1'b0, 2'b00, 16'h0, 16'h1111);

        // W=0: writes, then back-to-back reads with one req_n-high cycle between
        access(2, 0, 32'h0000_1000, 1'b1, 2'b00, 16'hA0A0, 16'h0);
        access(2, 0, 32'h0000_1002, 1'b1, 2'b00, 16'h0B0B, 16'h0);
        access(2, 0, 32'h0000_1000, 1'b0, 2'b00, 16'h0, 16'hA0A0);
        access(2, 0, 32'h0000_1002, 1'b0, 2'b00, 16'h0, 16'h0B0B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
